// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch stage with credit-limited request issue and fetch buffer
//
// Purpose:
//   Owns the fetch PC and issues in-order word reads to instruction memory. Returned
//   words are buffered together with their PCs and handed to the decoder over a
//   valid/ready handshake. A redirect restarts fetch at a new PC, flushing buffered
//   words and marking in-flight words for discard.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req_valid/ready/addr       word read request to instruction memory
//   imem_rsp_valid/data             in-order read response, no backpressure
//   redirect_valid/pc               single-cycle restart at redirect_pc (bits [1:0] ignored)
//   inst_valid/ready, inst, inst_pc buffered instruction stream to the decoder

module ifetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   CREDIT_MAX = (CW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [31:0]   fifo_inst [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;

  logic          credit_ok;
  logic          accept;
  logic          push;
  logic          pop;
  logic          drop;
  logic [CW-1:0] outstanding_nxt;
  logic [31:0]   redirect_target;

  // Buffered plus in-flight words never exceed the buffer size, so every response
  // that is kept is guaranteed a free slot.
  assign credit_ok       = ({1'b0, count} + {1'b0, outstanding}) < CREDIT_MAX;
  assign imem_req_valid  = rst_n & ~redirect_valid & credit_ok;
  assign imem_req_addr   = fetch_pc;
  assign accept          = imem_req_valid & imem_req_ready;

  assign drop            = imem_rsp_valid & (discard != '0);
  assign push            = imem_rsp_valid & (discard == '0) & ~redirect_valid;
  assign pop             = inst_valid & inst_ready & ~redirect_valid;

  assign inst_valid      = (count != '0);
  assign inst            = fifo_inst[rd_ptr];
  assign inst_pc         = fifo_pc[rd_ptr];

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    outstanding_nxt = outstanding;
    if (accept)         outstanding_nxt = outstanding_nxt + CNT_ONE;
    if (imem_rsp_valid) outstanding_nxt = outstanding_nxt - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]   <= '0;
        fifo_inst[i] <= '0;
      end
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        fetch_pc <= redirect_target;
        rsp_pc   <= redirect_target;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        // No request is accepted in a redirect cycle, so everything still in flight
        // after this edge is stale. Words already marked for discard are a subset of
        // the in-flight words, so this covers back-to-back redirects as well.
        discard  <= outstanding_nxt;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          fifo_pc[wr_ptr]   <= rsp_pc;
          fifo_inst[wr_ptr] <= imem_rsp_data;
          wr_ptr            <= wr_ptr + PTR_ONE;
          rsp_pc            <= rsp_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + PTR_ONE;
        if (push && !pop)      count <= count + CNT_ONE;
        else if (pop && !push) count <= count - CNT_ONE;
        if (drop) discard <= discard - CNT_ONE;
      end
    end
  end

  // A kept response arriving with the buffer full means the credit accounting broke.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      assert (count != CNT_FULL);
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - directed self-checking bench for ifetch

module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int          checks = 0;
  int          errors = 0;
  int          npop = 0;
  int          n;
  int          n0;
  int          lat = 1;
  logic [31:0] exp_pc = 32'h0;
  logic        pv [4];
  logic [31:0] pa [4];

  ifetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic clear_pipe();
    for (int i = 0; i < 4; i++) begin
      pv[i] = 1'b0;
      pa[i] = 32'h0;
    end
  endtask

  // One clock: sample handshakes at negedge, score any pop, then after the edge
  // advance the memory latency pipe and drop the redirect pulse.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    logic        p;
    @(negedge clk);
    acc = imem_req_valid & imem_req_ready;
    a   = imem_req_addr;
    p   = inst_valid & inst_ready & ~redirect_valid;
    if (p) begin
      check("sb_pc", inst_pc, exp_pc);
      check("sb_inst", inst, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      npop++;
    end
    @(posedge clk);
    #1;
    for (int i = 3; i > 0; i--) begin
      pv[i] = pv[i-1];
      pa[i] = pa[i-1];
    end
    pv[0] = acc;
    pa[0] = a;
    imem_rsp_valid = pv[lat-1];
    imem_rsp_data  = pv[lat-1] ? mem_word(pa[lat-1]) : 32'h0;
    redirect_valid = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_pipe();
    #1 rst_n = 1'b0;
    #1;
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("t1_first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("t1_first_req_addr", imem_req_addr, 32'h0);
    tick();
    check("t1_lat_not_yet", {31'b0, inst_valid}, 32'd0);
    tick();
    check("t1_lat_valid", {31'b0, inst_valid}, 32'd1);
    check("t1_lat_pc", inst_pc, 32'h0);
    tick();
    tick();

    // Memory stall at 0x10
    check("t3_addr_before", imem_req_addr, 32'h10);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", {31'b0, imem_req_valid}, 32'd1);
      check("t3_hold_addr", imem_req_addr, 32'h10);
      tick();
    end
    imem_req_ready = 1'b1;
    tick();
    check("t3_accepted_once", imem_req_addr, 32'h14);
    tick();

    // Sustained one instruction per cycle
    n0 = npop;
    for (int i = 0; i < 12; i++) begin
      check("t1_sustained_valid", {31'b0, inst_valid}, 32'd1);
      tick();
    end
    check("t1_pop_count", npop - n0, 32'd12);
    check("t1_exp_pc", exp_pc, 32'h40);

    // Decoder stall
    inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t2_head_stable", inst_pc, 32'h40);
    end
    check("t2_full_valid", {31'b0, inst_valid}, 32'd1);
    check("t2_full_inst", inst, mem_word(32'h40));
    check("t2_req_stopped", {31'b0, imem_req_valid}, 32'd0);
    check("t2_next_addr", imem_req_addr, 32'h50);
    inst_ready = 1'b1;
    n0 = npop;
    for (int i = 0; i < 8; i++) begin
      check("t2_resume_valid", {31'b0, inst_valid}, 32'd1);
      tick();
    end
    check("t2_resume_pops", npop - n0, 32'd8);
    check("t2_exp_pc", exp_pc, 32'h60);

    // Redirect with two words in flight
    inst_ready = 1'b0;
    repeat (6) tick();
    check("t4_idle_full", {31'b0, imem_req_valid}, 32'd0);
    lat = 4;
    clear_pipe();
    inst_ready     = 1'b1;
    redirect_pc    = 32'h20;
    redirect_valid = 1'b1;
    tick();
    exp_pc = 32'h20;
    check("t4_flush_valid", {31'b0, inst_valid}, 32'd0);
    check("t4_req_addr_20", imem_req_addr, 32'h20);
    tick();
    tick();
    check("t4_req_addr_28", imem_req_addr, 32'h28);
    redirect_pc    = 32'h103;
    redirect_valid = 1'b1;
    tick();
    exp_pc = 32'h100;
    check("t4_empty_after", {31'b0, inst_valid}, 32'd0);
    check("t4_new_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("t4_new_req_addr", imem_req_addr, 32'h100);
    n = 0;
    while (!inst_valid && n < 20) begin
      tick();
      n++;
    end
    check("t4_wait_cycles", n, 32'd5);
    check("t4_pc", inst_pc, 32'h100);
    check("t4_inst", inst, mem_word(32'h100));

    // Redirect coinciding with a response and a pop
    n = 0;
    while (!(inst_valid && imem_rsp_valid) && n < 20) begin
      tick();
      n++;
    end
    check("t5_setup_found", {31'b0, (n < 20)}, 32'd1);
    redirect_pc    = 32'h200;
    redirect_valid = 1'b1;
    tick();
    exp_pc = 32'h200;
    check("t5_empty_after", {31'b0, inst_valid}, 32'd0);
    check("t5_req_addr", imem_req_addr, 32'h200);
    n = 0;
    while (!inst_valid && n < 20) begin
      tick();
      n++;
    end
    check("t5_wait_bound", {31'b0, (n < 20)}, 32'd1);
    check("t5_pc", inst_pc, 32'h200);
    check("t5_inst", inst, mem_word(32'h200));
    n0 = npop;
    repeat (8) tick();
    check("t5_stream_moves", {31'b0, (npop > n0)}, 32'd1);

    // Reset mid-stream with the buffer full
    inst_ready = 1'b0;
    repeat (12) tick();
    check("t6_full_valid", {31'b0, inst_valid}, 32'd1);
    check("t6_full_req", {31'b0, imem_req_valid}, 32'd0);
    #2 rst_n = 1'b0;
    clear_pipe();
    imem_rsp_valid = 1'b0;
    #1;
    check("t6_async_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("t6_async_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("t6_async_req_addr", imem_req_addr, 32'h0);
    check("t6_async_inst", inst, 32'h0);
    check("t6_async_inst_pc", inst_pc, 32'h0);
    tick();
    tick();
    lat        = 1;
    inst_ready = 1'b1;
    exp_pc     = 32'h0;
    rst_n      = 1'b1;
    #1;
    check("t6_restart_valid", {31'b0, imem_req_valid}, 32'd1);
    check("t6_restart_addr", imem_req_addr, 32'h0);
    tick();
    check("t6_lat_not_yet", {31'b0, inst_valid}, 32'd0);
    tick();
    check("t6_first_valid", {31'b0, inst_valid}, 32'd1);
    check("t6_first_pc", inst_pc, 32'h0);
    n0 = npop;
    repeat (6) tick();
    check("t6_pops", npop - n0, 32'd6);
    check("t6_exp_pc", exp_pc, 32'h18);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
